// File: rtl/framebuffer_db.sv
// rtl/framebuffer_db.sv - double-buffered framebuffer with page flip and solid fill engine
// Optional FB_OUT_REG_EN adds an output register on rd_data/rd_valid (read latency 2).
module framebuffer_db #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int PIX_W  = 12,
  parameter int XW     = 9,
  parameter int YW     = 8,
  parameter int AW     = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  output logic             wr_oob,
  input  logic             rd_en,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  output logic             rd_valid,
  output logic [PIX_W-1:0] rd_data,
  input  logic             frame_start,
  input  logic             flip_req,
  output logic             flip_pending,
  output logic             front_page,
  input  logic             fill_start,
  input  logic [PIX_W-1:0] fill_color,
  output logic             fill_busy,
  output logic             fill_done
);

  localparam int            DEPTH    = 2 ** (AW + 1);
  localparam logic [31:0]   WIDTH_U  = WIDTH;
  localparam logic [31:0]   HEIGHT_U = HEIGHT;
  localparam logic [AW-1:0] LAST     = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  fill_state_t      state, state_next;
  logic [AW-1:0]    cnt;
  logic [PIX_W-1:0] fill_col;
  logic [PIX_W-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_lin, rd_lin;
  logic             wr_inb, rd_inb, wr_acc, do_flip;
  logic             rd_valid_q;
  logic [PIX_W-1:0] rd_data_q;

  assign wr_lin   = AW'(wr_y) * AW'(WIDTH) + AW'(wr_x);
  assign rd_lin   = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);
  assign wr_inb   = (32'(wr_x) < WIDTH_U) && (32'(wr_y) < HEIGHT_U);
  assign rd_inb   = (32'(rd_x) < WIDTH_U) && (32'(rd_y) < HEIGHT_U);
  assign wr_ready = !fill_busy;
  assign wr_acc   = wr_en && wr_ready;
  // A same-cycle flip_req counts, so a request landing on frame_start flips at once.
  assign do_flip  = frame_start && (flip_pending || flip_req) && !fill_busy;

  always_comb begin
    state_next = state;
    fill_busy  = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: if (fill_start) state_next = FILL;
      FILL: begin
        fill_busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        fill_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_col <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && fill_start) begin
        cnt      <= '0;
        fill_col <= fill_color;
      end else if (state == FILL) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Writes target the page that is back before this edge, even when a flip happens now.
  always_ff @(posedge clk) begin
    if (fill_busy)
      mem[{~front_page, cnt}] <= fill_col;
    else if (wr_acc && wr_inb)
      mem[{~front_page, wr_lin}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_page   <= 1'b0;
      flip_pending <= 1'b0;
      wr_oob       <= 1'b0;
    end else begin
      wr_oob <= wr_acc && !wr_inb;
      if (do_flip) begin
        front_page   <= ~front_page;
        flip_pending <= 1'b0;
      end else if (flip_req) begin
        flip_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en)
        rd_data_q <= rd_inb ? mem[{front_page, rd_lin}] : '0;
    end
  end

`ifdef FB_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_valid_q;
      if (rd_valid_q) rd_data <= rd_data_q;
    end
  end
`else
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`endif

endmodule
